// File: rtl/acc_mem_loader.sv
// acc_mem_loader: streams a batch of WORDS data words into the shared data
// memory while the accumulator controller is held in reset. It then releases
// that reset and waits for the controller's Ready pulse before starting the
// next batch.
// Optional feature: define ACC_LOADER_TIMEOUT_EN to abandon a RUN phase
// after TIMEOUT cycles without Ready. That path raises a sticky Error.
module acc_mem_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int WORDS      = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] InData,
  input  logic                  InValid,
  output logic                  InReady,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0] MemData,
  output logic                  MemWriteEnable,
  output logic                  AccReset,
  input  logic                  AccReady,
  output logic                  Busy,
  output logic                  BatchDone,
  output logic [7:0]            BatchCount,
  output logic                  Error
);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(WORDS - 1);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  handshake;
  logic                  last_word;
  logic                  ready_seen;
  logic                  timeout_hit;

  if (WORDS < 1 || WORDS > (1 << ADDR_WIDTH) || TIMEOUT < 1) begin : g_param_check
    $error("acc_mem_loader: WORDS must be 1..2**ADDR_WIDTH and TIMEOUT at least 1");
  end

  assign handshake  = InReady && InValid;
  assign last_word  = (ptr == LAST_PTR);
  // Ready only counts while RUN is the current state; SETTLE and LOAD ignore it.
  assign ready_seen = (state == RUN) && AccReady;

`ifdef ACC_LOADER_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_cnt;

  // Wait counter: zero on the first RUN cycle, +1 for every RUN cycle after.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wait_cnt <= '0;
    end else if (state == SETTLE) begin
      wait_cnt <= '0;
    end else if (state == RUN) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // The TIMEOUT-th RUN edge without Ready abandons the batch.
  assign timeout_hit = (state == RUN) && !AccReady && (wait_cnt == WAIT_LAST);

  // Error is sticky until the next Reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Error <= 1'b0;
    end else if (timeout_hit) begin
      Error <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign Error       = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: LOAD -> SETTLE on the final word, SETTLE -> RUN always,
  // RUN -> LOAD on Ready (or on a timeout).
  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (handshake && last_word) state_next = SETTLE;
      SETTLE:  state_next = RUN;
      RUN:     if (ready_seen || timeout_hit) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // State-decoded outputs: the stream is accepted only while loading.
  always_comb begin
    InReady = (state == LOAD);
    Busy    = (state != LOAD);
  end

  // Memory write port: one registered strobe per accepted word. Address and
  // data hold their last values between writes.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ptr            <= '0;
      MemWriteEnable <= 1'b0;
      MemAddress     <= '0;
      MemData        <= '0;
    end else begin
      MemWriteEnable <= handshake;
      if (handshake) begin
        MemAddress <= ptr;
        MemData    <= InData;
        ptr        <= last_word ? '0 : ptr + 1'b1;
      end
    end
  end

  // Accumulator handoff: release its reset when leaving SETTLE. Take it back
  // (and report the batch) on the edge that samples Ready.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      AccReset   <= 1'b0;
      BatchDone  <= 1'b0;
      BatchCount <= '0;
    end else begin
      BatchDone <= ready_seen;
      if (state == SETTLE) begin
        AccReset <= 1'b1;
      end else if (ready_seen || timeout_hit) begin
        AccReset <= 1'b0;
      end
      if (ready_seen) begin
        BatchCount <= BatchCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_acc_mem_loader.sv
// Bench for acc_mem_loader. Stimulus is random, and the bench predicts every output
// from a batch-level model: words accepted so far, loading/settling/running
// phase, and completed batch count.
module tb_acc_mem_loader;
  localparam int DW = 8;
  localparam int AW = 6;
  localparam int NW = 32;
  localparam int TO = 20;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [DW-1:0] InData;
  logic          InValid;
  logic          InReady;
  logic [AW-1:0] MemAddress;
  logic [DW-1:0] MemData;
  logic          MemWriteEnable;
  logic          AccReset;
  logic          AccReady;
  logic          Busy;
  logic          BatchDone;
  logic [7:0]    BatchCount;
  logic          Error;

  acc_mem_loader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORDS(NW), .TIMEOUT(TO)
  ) dut (
    .Clock(Clock), .Reset(Reset), .InData(InData), .InValid(InValid),
    .InReady(InReady), .MemAddress(MemAddress), .MemData(MemData),
    .MemWriteEnable(MemWriteEnable), .AccReset(AccReset), .AccReady(AccReady),
    .Busy(Busy), .BatchDone(BatchDone), .BatchCount(BatchCount), .Error(Error)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = loading, 1 = settling, 2 = running.
  int            m_phase;
  int            m_words;
  int            m_count;
  int            m_wait;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic          e_we;
  logic          e_accrst;
  logic          e_done;
  logic          e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    chk("InReady", InReady, m_phase == 0);
    chk("Busy", Busy, m_phase != 0);
    chk("MemWriteEnable", MemWriteEnable, e_we);
    chk("MemAddress", MemAddress, e_addr);
    chk("MemData", MemData, e_data);
    chk("AccReset", AccReset, e_accrst);
    chk("BatchDone", BatchDone, e_done);
    chk("BatchCount", BatchCount, m_count);
    chk("Error", Error, e_err);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    #1;
    m_phase = 0; m_words = 0; m_count = 0; m_wait = 0;
    e_addr = '0; e_data = '0; e_we = 1'b0; e_accrst = 1'b0;
    e_done = 1'b0; e_err = 1'b0;
    check_outputs();
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  // One clock edge: predict from the inputs seen before it, then compare.
  task automatic tick();
    logic          hs;
    logic          ar;
    logic [DW-1:0] d;
    hs = (m_phase == 0) && InValid;
    ar = AccReady;
    d  = InData;
    @(posedge Clock);
    #1;
    e_we   = hs;
    e_done = 1'b0;
    case (m_phase)
      0: if (hs) begin
        e_addr = m_words[AW-1:0];
        e_data = d;
        m_words++;
        if (m_words == NW) begin
          m_words = 0;
          m_phase = 1;
        end
      end
      1: begin
        m_phase  = 2;
        e_accrst = 1'b1;
        m_wait   = 0;
      end
      default: begin
        if (ar) begin
          e_accrst = 1'b0;
          e_done   = 1'b1;
          m_count  = (m_count + 1) % 256;
          m_phase  = 0;
        end
`ifdef ACC_LOADER_TIMEOUT_EN
        else begin
          m_wait++;
          if (m_wait == TO) begin
            e_accrst = 1'b0;
            e_err    = 1'b1;
            m_phase  = 0;
          end
        end
`endif
      end
    endcase
    check_outputs();
  endtask

  // Random valid gaps, random data and random (ignored) Ready until the batch is in.
  task automatic load_rest();
    int guard = 0;
    while (m_phase == 0 && guard < 2000) begin
      InValid  = 1'($urandom_range(0, 1));
      InData   = DW'($urandom);
      AccReady = 1'($urandom_range(0, 1));
      tick();
      guard++;
    end
    InValid = 1'b0;
    chk("load_bound", m_phase != 0, 1);
  endtask

  // Assert Ready from the delay-th iteration onward until the batch is complete.
  task automatic finish_run(input int delay);
    int n = 0;
    while (m_phase != 0 && n < 300) begin
      AccReady = (n >= delay);
      InValid  = 1'($urandom_range(0, 1));
      InData   = DW'($urandom);
      tick();
      n++;
    end
    AccReady = 1'b0;
    InValid  = 1'b0;
    chk("run_bound", m_phase == 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; InValid = 1'b0; InData = '0; AccReady = 1'b0;
    #2;
    do_reset();

    // Back-to-back batch, data equal to address.
    for (int i = 0; i < NW; i++) begin
      InValid = 1'b1;
      InData  = DW'(i);
      tick();
    end
    // Settle and run with valid stream traffic that must be ignored.
    for (int i = 0; i < 5; i++) begin
      InValid = 1'b1;
      InData  = DW'($urandom);
      tick();
    end
    InValid  = 1'b0;
    AccReady = 1'b1;
    tick();
    AccReady = 1'b0;
    tick();

    // Gapped start of batch 2, then Ready held through load and settle.
    InValid = 1'b1; InData = 8'hA5; tick();
    InValid = 1'b0; InData = 8'hFF; tick();
    InValid = 1'b1; InData = 8'hB6; tick();
    InValid = 1'b0; tick();
    AccReady = 1'b1;
    while (m_phase == 0) begin
      InValid = 1'($urandom_range(0, 1));
      InData  = DW'($urandom);
      tick();
    end
    InValid = 1'b0;
    tick();
    tick();
    AccReady = 1'b0;
    tick();

    // Random batches.
    for (int b = 0; b < 3; b++) begin
      load_rest();
      finish_run(int'($urandom_range(0, 10)));
    end

    // Reset after 10 words, then restart from address 0.
    for (int i = 0; i < 10; i++) begin
      InValid = 1'b1;
      InData  = DW'($urandom);
      tick();
    end
    InValid = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      InValid = 1'b1;
      InData  = DW'($urandom);
      tick();
    end
    load_rest();
    finish_run(3);

`ifdef ACC_LOADER_TIMEOUT_EN
    // No Ready: the run is abandoned after TO RUN cycles.
    load_rest();
    AccReady = 1'b0;
    for (int i = 0; i < TO + 5; i++) tick();
    chk("timeout_error", Error, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
